// File: rtl/rv32_hpm_counters.sv
// Machine-mode HPM bank: NUM_COUNTERS event counters with per-counter event
// selector, sticky overflow flag and overflow interrupt, plus HPM inhibit bits.
package rv32_hpm_pkg;
  typedef struct packed {
    logic        write;
    logic [11:0] id;
    logic [31:0] value;
  } csr_write_request_t;
endpackage

module rv32_hpm_counter #(
  parameter int CW = 64,
  parameter int NE = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inhibit,
  input  logic [NE-1:0] events,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic          wr_evt,
  input  logic [31:0]   wdata,
  output logic [CW-1:0] cnt,
  output logic [SW-1:0] sel,
  output logic          oie,
  output logic          of
);
  // Bit 0 stands in for sel=0 ("no event"), so sel indexes directly.
  logic [NE:0]   ev_ext;
  logic          inc, wrap;
  logic [31:0]   lo_inc;
  logic [SW-1:0] sel_w, sel_legal;

  assign ev_ext    = {events, 1'b0};
  assign inc       = !inhibit && ev_ext[sel];
  assign wrap      = inc && !wr_lo && !wr_hi && (&cnt);
  assign lo_inc    = cnt[31:0] + 32'(inc);
  assign sel_w     = wdata[SW-1:0];
  assign sel_legal = (32'(sel_w) <= NE) ? sel_w : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      sel <= '0;
      oie <= 1'b0;
      of  <= 1'b0;
    end else begin
      // Software writes beat the increment; a high-half write keeps the
      // low-half increment but drops its carry.
      if (wr_lo)
        cnt[31:0] <= wdata;
      else if (wr_hi) begin
        cnt[CW-1:32] <= wdata[CW-33:0];
        cnt[31:0]    <= lo_inc;
      end else if (inc)
        cnt <= cnt + CW'(1);

      if (wr_evt) begin
        sel <= sel_legal;
        oie <= wdata[30];
        of  <= wdata[31] | wrap;
      end else if (wrap)
        of <= 1'b1;
    end
  end
endmodule

module rv32_hpm_counters
  import rv32_hpm_pkg::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [11:0]           read_id,
  output logic [31:0]           read_value,
  output logic                  read_hit,
  input  csr_write_request_t    write_request,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  overflow_irq
);
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);

  logic [NUM_COUNTERS-1:0]                    inhibit;
  logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] cnt;
  logic [NUM_COUNTERS-1:0][SEL_W-1:0]         sel;
  logic [NUM_COUNTERS-1:0]                    oie, of;

  always_ff @(posedge clk) begin
    if (!resetn)
      inhibit <= '0;
    else if (write_request.write && write_request.id == 12'h320)
      inhibit <= write_request.value[3 +: NUM_COUNTERS];
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    localparam logic [11:0] A_LO  = 12'(12'hB03 + i);
    localparam logic [11:0] A_HI  = 12'(12'hB83 + i);
    localparam logic [11:0] A_EVT = 12'(12'h323 + i);

    rv32_hpm_counter #(.CW(COUNTER_WIDTH), .NE(NUM_EVENTS), .SW(SEL_W)) u_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .inhibit (inhibit[i]),
      .events  (events),
      .wr_lo   (write_request.write && write_request.id == A_LO),
      .wr_hi   (write_request.write && write_request.id == A_HI),
      .wr_evt  (write_request.write && write_request.id == A_EVT),
      .wdata   (write_request.value),
      .cnt     (cnt[i]),
      .sel     (sel[i]),
      .oie     (oie[i]),
      .of      (of[i])
    );
  end

  assign overflow_irq = |(of & oie);

  logic [31:0] hi_rd, evt_rd;

  always_comb begin
    read_hit   = 1'b0;
    read_value = '0;
    hi_rd      = '0;
    evt_rd     = '0;
    if (read_id == 12'h320) begin
      read_hit                    = 1'b1;
      read_value[3 +: NUM_COUNTERS] = inhibit;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      hi_rd                      = '0;
      hi_rd[COUNTER_WIDTH-33:0]  = cnt[i][COUNTER_WIDTH-1:32];
      evt_rd                     = '0;
      evt_rd[SEL_W-1:0]          = sel[i];
      evt_rd[30]                 = oie[i];
      evt_rd[31]                 = of[i];
      if (read_id == 12'(12'hB03 + i)) begin
        read_hit   = 1'b1;
        read_value = cnt[i][31:0];
      end
      if (read_id == 12'(12'hB83 + i)) begin
        read_hit   = 1'b1;
        read_value = hi_rd;
      end
      if (read_id == 12'(12'h323 + i)) begin
        read_hit   = 1'b1;
        read_value = evt_rd;
      end
    end
  end
endmodule
